// File: rtl/qpll_seq_pkg.sv
// Shared definitions for the QPLL bring-up sequencer: state encoding,
// retry counter width and the state-to-pin decode table.
package qpll_seq_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    typedef struct packed {
        logic pd;
        logic reset;
        logic lock_en;
        logic ready;
        logic fail;
    } qpll_out_t;

    // Pin levels for each state; unlisted states park the QPLL powered down.
    function automatic qpll_out_t decode_out(input state_t s);
        qpll_out_t o;
        o = '{pd: 1'b1, reset: 1'b1, lock_en: 1'b0, ready: 1'b0, fail: 1'b0};
        case (s)
            ST_RESET:     o = '{pd: 1'b0, reset: 1'b1, lock_en: 1'b1, ready: 1'b0, fail: 1'b0};
            ST_WAIT_LOCK: o = '{pd: 1'b0, reset: 1'b0, lock_en: 1'b1, ready: 1'b0, fail: 1'b0};
            ST_READY:     o = '{pd: 1'b0, reset: 1'b0, lock_en: 1'b1, ready: 1'b1, fail: 1'b0};
            ST_FAIL:      o = '{pd: 1'b1, reset: 1'b1, lock_en: 1'b0, ready: 1'b0, fail: 1'b1};
            default:      o = '{pd: 1'b1, reset: 1'b1, lock_en: 1'b0, ready: 1'b0, fail: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/qpll_bringup_ctrl.sv
// Power-up/reset sequencer for a GTXE2_COMMON QPLL: waits for the fabric PLL,
// cycles QPLLPD/QPLLRESET, waits for QPLLLOCK with retries, reports ready/fail.
module qpll_bringup_ctrl
    import qpll_seq_pkg::*;
#(
    parameter int PD_CYCLES    = 500,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 200000,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               qpll_lock,
    input  logic               qpll_refclk_lost,
    input  logic               restart,
    output logic               qpll_pd,
    output logic               qpll_reset,
    output logic               qpll_lock_en,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0]   PD_LAST   = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [2:0] sync_q;
    logic       pll_s;
    logic       lock_s;
    logic       refclk_lost_s;

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({qpll_refclk_lost, qpll_lock, pll_locked}),
        .q   (sync_q)
    );

    assign pll_s         = sync_q[0];
    assign lock_s        = sync_q[1];
    assign refclk_lost_s = sync_q[2];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    qpll_out_t          out_q;

    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        // A restart pulse always clears the attempt history, even when a
        // simultaneous PLL loss is what actually steers the state to IDLE.
        if (restart) begin
            retry_d = '0;
        end
        if (!pll_s && state_q != ST_IDLE && state_q != ST_FAIL) begin
            state_d = ST_IDLE;
        end else if (restart) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pll_s) state_d = ST_PWRDN;
                end
                ST_PWRDN: begin
                    if (cnt_q == PD_LAST) state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_READY;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc > RETRY_MAX) ? ST_FAIL : ST_PWRDN;
                    end
                end
                ST_READY: begin
                    if (!lock_s || refclk_lost_s) state_d = ST_PWRDN;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Only the timed phases count; the counter restarts on every entry.
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == ST_PWRDN || state_q == ST_RESET || state_q == ST_WAIT_LOCK)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pins are decoded from the next state so they change with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            out_q   <= decode_out(ST_IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            out_q   <= decode_out(state_d);
        end
    end

    assign qpll_pd      = out_q.pd;
    assign qpll_reset   = out_q.reset;
    assign qpll_lock_en = out_q.lock_en;
    assign ready        = out_q.ready;
    assign fail         = out_q.fail;
    assign retry_cnt    = retry_q;
    assign state        = state_q;

endmodule

// File: tb/tb_qpll_bringup_ctrl.sv
// Self-checking bench for qpll_bringup_ctrl: per-cycle input schedules are replayed
// and the observed state/pins are compared against timelines built from the sequencing rules.
module tb_qpll_bringup_ctrl;

    localparam int PD    = 8;
    localparam int RS    = 4;
    localparam int TO    = 50;
    localparam int MAXR  = 2;
    localparam int MAXT  = 512;
    localparam int NEVER = 1000000;
    localparam int ATT   = PD + RS + TO;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PWRDN = 3'd1;
    localparam logic [2:0] S_RESET = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

    // Bit positions inside an input schedule word.
    localparam int B_RST   = 4;
    localparam int B_PLL   = 3;
    localparam int B_LOCK  = 2;
    localparam int B_RLOST = 1;
    localparam int B_RSTRT = 0;

    logic       clk = 1'b0;
    logic       rst, pll_locked, qpll_lock, qpll_refclk_lost, restart;
    logic       qpll_pd, qpll_reset, qpll_lock_en, ready, fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    logic [4:0]  in_v   [MAXT];
    logic [2:0]  exp_st [MAXT];
    logic [3:0]  exp_rc [MAXT];
    logic [11:0] obs    [MAXT];
    int          ecur;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    qpll_bringup_ctrl #(
        .PD_CYCLES    (PD),
        .RST_CYCLES   (RS),
        .LOCK_TIMEOUT (TO),
        .MAX_RETRIES  (MAXR),
        .CNT_W        (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pll_locked       (pll_locked),
        .qpll_lock        (qpll_lock),
        .qpll_refclk_lost (qpll_refclk_lost),
        .restart          (restart),
        .qpll_pd          (qpll_pd),
        .qpll_reset       (qpll_reset),
        .qpll_lock_en     (qpll_lock_en),
        .ready            (ready),
        .fail             (fail),
        .retry_cnt        (retry_cnt),
        .state            (state)
    );

    task automatic hard_reset();
        rst = 1'b1; pll_locked = 1'b0; qpll_lock = 1'b0;
        qpll_refclk_lost = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- reference timeline ----------------
    // {pd, reset, lock_en, ready, fail} for each state.
    function automatic logic [4:0] pins_of(input logic [2:0] st);
        case (st)
            S_IDLE, S_PWRDN: return 5'b11000;
            S_RESET:         return 5'b01100;
            S_WAIT:          return 5'b00100;
            S_READY:         return 5'b00110;
            S_FAIL:          return 5'b11001;
            default:         return 5'b00000;
        endcase
    endfunction

    function automatic logic [11:0] exp_word(input int i);
        return {exp_st[i], pins_of(exp_st[i]), exp_rc[i]};
    endfunction

    task automatic init_trace(input logic [4:0] v);
        for (int i = 0; i < MAXT; i++) in_v[i] = v;
        ecur = 0;
    endtask

    task automatic set_in(input int b, input int from, input int to, input logic v);
        for (int i = from; i <= to && i < MAXT; i++) in_v[i][b] = v;
    endtask

    task automatic exp_run(input logic [2:0] st, input logic [3:0] rc, input int n);
        for (int i = 0; i < n; i++) begin
            exp_st[ecur] = st;
            exp_rc[ecur] = rc;
            ecur++;
        end
    endtask

    // Appends PWRDN/RESET/WAIT attempts from the current cursor. A lock applied at
    // input cycle lock_in is visible 3 cycles later, but only counts inside WAIT_LOCK.
    task automatic build_attempts(input int lock_in, inout logic [3:0] r, output bit locked);
        locked = 1'b0;
        for (int a = 0; a < 16; a++) begin
            int w, rdy;
            exp_run(S_PWRDN, r, PD);
            exp_run(S_RESET, r, RS);
            w   = ecur;
            rdy = (lock_in + 3 > w + 1) ? lock_in + 3 : w + 1;
            if (rdy <= w + TO) begin
                exp_run(S_WAIT, r, rdy - w);
                locked = 1'b1;
                return;
            end
            exp_run(S_WAIT, r, TO);
            if (r != 4'd15) r = r + 4'd1;
            if (r > MAXR) return;
        end
    endtask

    // ---------------- driver ----------------
    // Observe at each falling edge, then apply that cycle's inputs.
    task automatic run_trace();
        for (int i = 0; i < ecur; i++) begin
            @(negedge clk);
            obs[i] = {state, qpll_pd, qpll_reset, qpll_lock_en, ready, fail, retry_cnt};
            {rst, pll_locked, qpll_lock, qpll_refclk_lost, restart} = in_v[i];
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        hard_reset();
        init_trace(5'b11110);
        exp_run(S_IDLE, 4'd0, 6);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL reset cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
    endtask

    task automatic test_nominal();
        int l, pd_hi, rst_only, first_rdy;
        logic [3:0] r;
        bit ok;
        hard_reset();
        init_trace(5'b10000);
        set_in(B_RST, 4, MAXT - 1, 1'b0);
        set_in(B_PLL, 10, MAXT - 1, 1'b1);
        l = 27 + $urandom_range(0, 20);
        set_in(B_LOCK, l, MAXT - 1, 1'b1);
        r = 4'd0;
        exp_run(S_IDLE, r, 13);
        build_attempts(l, r, ok);
        exp_run(S_READY, r, 10);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL nominal cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
        pd_hi = 0; rst_only = 0; first_rdy = -1;
        for (int i = 13; i < ecur; i++) begin
            if (obs[i][8]) pd_hi++;
            if (obs[i][7] && !obs[i][8]) rst_only++;
            if (obs[i][5] && first_rdy < 0) first_rdy = i;
        end
        checks++;
        if (pd_hi !== PD) begin
            errors++;
            $display("FAIL nominal_pd_width: got %0d cycles expected %0d", pd_hi, PD);
        end
        checks++;
        if (rst_only !== RS) begin
            errors++;
            $display("FAIL nominal_reset_width: got %0d cycles expected %0d", rst_only, RS);
        end
        checks++;
        if (first_rdy < l + 1 || first_rdy > l + 3) begin
            errors++;
            $display("FAIL nominal_ready_latency: got %0d cycles expected 1..3", first_rdy - l);
        end
    endtask

    task automatic test_timeout_fail();
        int waits;
        logic [3:0] r;
        bit ok;
        hard_reset();
        init_trace(5'b01000);
        r = 4'd0;
        exp_run(S_IDLE, r, 3);
        build_attempts(NEVER, r, ok);
        exp_run(S_FAIL, r, 10);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL timeout cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
        waits = 0;
        for (int i = 0; i < ecur; i++) if (obs[i][11:9] == S_WAIT) waits++;
        checks++;
        if (waits !== (MAXR + 1) * TO) begin
            errors++;
            $display("FAIL timeout_wait_cycles: got %0d expected %0d", waits, (MAXR + 1) * TO);
        end
        checks++;
        if ({fail, qpll_pd, qpll_reset, retry_cnt} !== {3'b111, 4'(MAXR + 1)}) begin
            errors++;
            $display("FAIL timeout_final: got fail=%b pd=%b reset=%b rc=%0d expected 1 1 1 %0d",
                     fail, qpll_pd, qpll_reset, retry_cnt, MAXR + 1);
        end
    endtask

    // Starts in FAIL; restart, first attempt times out, second one locks.
    task automatic test_restart();
        int l;
        logic [3:0] r;
        bit ok;
        init_trace(5'b01000);
        set_in(B_RSTRT, 2, 2, 1'b1);
        exp_run(S_FAIL, 4'(MAXR + 1), 3);
        exp_run(S_IDLE, 4'd0, 1);
        l = 4 + 2 * (PD + RS) + TO + $urandom_range(0, 39) - 9;
        set_in(B_LOCK, l, MAXT - 1, 1'b1);
        r = 4'd0;
        build_attempts(l, r, ok);
        exp_run(S_READY, r, 10);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL restart cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
        checks++;
        if ({ready, fail, retry_cnt} !== 6'b10_0001) begin
            errors++;
            $display("FAIL restart_final: got ready=%b fail=%b rc=%0d expected 1 0 1", ready, fail, retry_cnt);
        end
    endtask

    // Starts in READY with one failed attempt on record.
    task automatic test_lock_loss();
        int first_drop, w;
        logic [3:0] r;
        bit ok;
        init_trace(5'b01100);
        set_in(B_LOCK, 2, 6, 1'b0);
        r = 4'd1;
        exp_run(S_READY, r, 5);
        build_attempts(7, r, ok);
        exp_run(S_READY, r, 5);
        run_trace();
        first_drop = -1;
        for (int i = 0; i < ecur; i++) begin
            if (!obs[i][5] && first_drop < 0) first_drop = i;
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL lock_loss cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
        checks++;
        if (first_drop < 3 || first_drop > 5) begin
            errors++;
            $display("FAIL lock_loss_latency: got %0d cycles expected 1..3", first_drop - 2);
        end

        w = $urandom_range(1, 3);
        init_trace(5'b01100);
        set_in(B_RLOST, 2, 1 + w, 1'b1);
        exp_run(S_READY, r, 5);
        build_attempts(-10, r, ok);
        exp_run(S_READY, r, 5);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL refclk_lost cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
    endtask

    // One timeout, then pll_locked drops during the second RESET phase.
    task automatic test_pll_loss();
        int rs_start, d, e;
        logic [3:0] r;
        bit ok;
        hard_reset();
        init_trace(5'b01000);
        rs_start = 3 + ATT + PD;
        d = rs_start - 2 + $urandom_range(0, RS - 1);
        e = d + 8;
        set_in(B_PLL, d, e - 1, 1'b0);
        set_in(B_LOCK, e, MAXT - 1, 1'b1);
        exp_run(S_IDLE, 4'd0, 3);
        exp_run(S_PWRDN, 4'd0, PD);
        exp_run(S_RESET, 4'd0, RS);
        exp_run(S_WAIT, 4'd0, TO);
        exp_run(S_PWRDN, 4'd1, PD);
        exp_run(S_RESET, 4'd1, d + 3 - ecur);
        exp_run(S_IDLE, 4'd1, e + 3 - ecur);
        r = 4'd1;
        build_attempts(e, r, ok);
        exp_run(S_READY, r, 5);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL pll_loss cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
    endtask

    // restart and pll_locked fall together in READY. restart is acted on at once,
    // the PLL loss only after the synchronizer, so one PWRDN cycle slips in between.
    task automatic test_priority();
        init_trace(5'b01100);
        set_in(B_RSTRT, 2, 2, 1'b1);
        set_in(B_PLL, 2, MAXT - 1, 1'b0);
        exp_run(S_READY, 4'd1, 3);
        exp_run(S_IDLE, 4'd0, 1);
        exp_run(S_PWRDN, 4'd0, 1);
        exp_run(S_IDLE, 4'd0, 8);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL priority cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
    endtask

    task automatic test_rst_mid();
        int k;
        hard_reset();
        init_trace(5'b01000);
        k = 3 + PD + RS + $urandom_range(0, TO - 1);
        set_in(B_RST, k, MAXT - 1, 1'b1);
        exp_run(S_IDLE, 4'd0, 3);
        exp_run(S_PWRDN, 4'd0, PD);
        exp_run(S_RESET, 4'd0, RS);
        exp_run(S_WAIT, 4'd0, k + 1 - ecur);
        exp_run(S_IDLE, 4'd0, 5);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL rst_mid cycle %0d: got {st,pins,rc}=%03h expected %03h", i, obs[i], exp_word(i));
            end
        end
        checks++;
        if (obs[k + 1] !== 12'b000_11000_0000) begin
            errors++;
            $display("FAIL rst_mid_values: got %03h expected %03h", obs[k + 1], 12'b000_11000_0000);
        end
    endtask

    // Random number of failed attempts; lock lands somewhere around the last attempt.
    task automatic test_random_attempts();
        int f, l;
        logic [3:0] r;
        bit ok;
        hard_reset();
        init_trace(5'b01000);
        f = $urandom_range(0, MAXR + 1);
        l = (f <= MAXR) ? 3 + f * ATT + PD + RS + $urandom_range(0, 44) - 9 : NEVER;
        if (l < NEVER) set_in(B_LOCK, l, MAXT - 1, 1'b1);
        r = 4'd0;
        exp_run(S_IDLE, r, 3);
        build_attempts(l, r, ok);
        exp_run(ok ? S_READY : S_FAIL, r, 8);
        run_trace();
        for (int i = 0; i < ecur; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL random(f=%0d) cycle %0d: got {st,pins,rc}=%03h expected %03h", f, i, obs[i], exp_word(i));
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1; pll_locked = 1'b0; qpll_lock = 1'b0;
        qpll_refclk_lost = 1'b0; restart = 1'b0;
        test_reset();
        repeat (3) test_nominal();
        test_timeout_fail();
        test_restart();
        test_lock_loss();
        test_pll_loss();
        test_priority();
        test_rst_mid();
        repeat (4) test_random_attempts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
